mem_arbiter_rr: RTL and testbench

Parametrised round-robin arbiter that shares one synchronous single-port 16-bit SRAM among NUM_CH write-source channels (EP2/ADC side) and NUM_CH read-sink channels (EP6/DAC side). Each channel owns a fixed ring-buffer region in SRAM and is serviced in bounded bursts. Per-channel fill tracking, backpressure, enable and clear are provided. It sits between the port FIFOs and the cellram controller.

---
 rtl/mem_arbiter_rr.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter_rr.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_rr.sv
// Round-robin SRAM arbiter: NUM_CH write-source channels and NUM_CH read-sink
// channels share one single-port synchronous SRAM. Each channel owns a ring
// region of 2^DEPTH_LOG2 words. Channels are serviced in bursts of at most
// MAX_BURST accesses.
module mem_arbiter_rr #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int DEPTH_LOG2 = 10,
  parameter int ADDR_W     = 23,
  parameter int MAX_BURST  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              ch_enable,
  input  logic [NUM_CH-1:0]              ch_clear,
  input  logic [NUM_CH*DATA_W-1:0]       wsrc_data,
  input  logic [NUM_CH-1:0]              wsrc_valid,
  output logic [NUM_CH-1:0]              wsrc_rd,
  output logic [DATA_W-1:0]              rdst_data,
  output logic [NUM_CH-1:0]              rdst_wr,
  input  logic [NUM_CH-1:0]              rdst_afull,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [NUM_CH*(DEPTH_LOG2+1)-1:0] fill,
  output logic [NUM_CH-1:0]              full,
  output logic [NUM_CH*32-1:0]           wr_total
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int FILL_W = DEPTH_LOG2 + 1;
  localparam int BCNT_W = $clog2(MAX_BURST + 1);
  localparam logic [FILL_W-1:0] DEPTH     = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [BCNT_W-1:0] BURST_MAX = BCNT_W'(MAX_BURST);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);

  typedef enum logic {ST_SCAN, ST_BURST} state_t;

  state_t              state;
  logic                slot_rd;   // 0 = write slots W*, 1 = read slots R*
  logic [CH_W-1:0]     slot_ch;
  logic [BCNT_W-1:0]   bcnt;

  logic [DEPTH_LOG2-1:0] wp       [NUM_CH];
  logic [DEPTH_LOG2-1:0] rp       [NUM_CH];
  logic [FILL_W-1:0]     fill_q   [NUM_CH];
  logic [31:0]           total_q  [NUM_CH];
  logic [NUM_CH-1:0]     rdst_wr_q;

  logic [DATA_W-1:0]     src_word [NUM_CH];
  logic [FILL_W-1:0]     cur_fill;
  logic                  wr_elig;
  logic                  rd_elig;
  logic                  slot_elig;
  logic                  burst_go;
  logic                  acc_wr;
  logic                  acc_rd;
  logic [ADDR_W-1:0]     base;

  // Current-slot eligibility and the per-cycle access decision
  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      src_word[c] = wsrc_data[c*DATA_W +: DATA_W];
    end
    cur_fill  = fill_q[slot_ch];
    wr_elig   = ch_enable[slot_ch] && wsrc_valid[slot_ch] && (cur_fill != DEPTH);
    rd_elig   = ch_enable[slot_ch] && (cur_fill != '0) && !rdst_afull[slot_ch];
    slot_elig = slot_rd ? rd_elig : wr_elig;
    // A clear on the serviced channel kills the access in the same cycle
    burst_go  = (state == ST_BURST) && slot_elig && !ch_clear[slot_ch] &&
                (bcnt < BURST_MAX) && !reset;
    acc_wr    = burst_go && !slot_rd;
    acc_rd    = burst_go && slot_rd;
    base      = ADDR_W'(slot_ch) << DEPTH_LOG2;
  end

  // SRAM and FIFO strobes, driven combinationally from the access decision
  always_comb begin
    mem_en    = burst_go;
    mem_we    = acc_wr;
    mem_addr  = '0;
    mem_wdata = '0;
    wsrc_rd   = '0;
    if (acc_wr) begin
      mem_addr         = base | ADDR_W'(wp[slot_ch]);
      mem_wdata        = src_word[slot_ch];
      wsrc_rd[slot_ch] = 1'b1;
    end else if (acc_rd) begin
      mem_addr = base | ADDR_W'(rp[slot_ch]);
    end
    rdst_wr   = reset ? '0 : rdst_wr_q;
    rdst_data = (!reset && (rdst_wr_q != '0)) ? mem_rdata : '0;
  end

  // Flatten per-channel status onto the packed output buses
  always_comb begin
    fill     = '0;
    full     = '0;
    wr_total = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      fill[c*FILL_W +: FILL_W] = fill_q[c];
      full[c]                  = (fill_q[c] == DEPTH);
      wr_total[c*32 +: 32]     = total_q[c];
    end
  end

  // Slot scheduler: SCAN tests one slot per cycle, BURST issues accesses
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_SCAN;
      slot_rd <= 1'b0;
      slot_ch <= '0;
      bcnt    <= '0;
    end else begin
      case (state)
        ST_SCAN: begin
          if (slot_elig) begin
            state <= ST_BURST;
            bcnt  <= '0;
          end else if (slot_ch == LAST_CH) begin
            slot_ch <= '0;
            slot_rd <= ~slot_rd;
          end else begin
            slot_ch <= slot_ch + 1'b1;
          end
        end
        ST_BURST: begin
          if (burst_go) begin
            bcnt <= bcnt + 1'b1;
          end else begin
            state <= ST_SCAN;
            if (slot_ch == LAST_CH) begin
              slot_ch <= '0;
              slot_rd <= ~slot_rd;
            end else begin
              slot_ch <= slot_ch + 1'b1;
            end
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

  // Per-channel pointers, occupancy, write totals and the read-return strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      rdst_wr_q <= '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        wp[c]      <= '0;
        rp[c]      <= '0;
        fill_q[c]  <= '0;
        total_q[c] <= '0;
      end
    end else begin
      // Return strobe trails the issue by one cycle, independent of later clears
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        rdst_wr_q[c] <= acc_rd && (slot_ch == CH_W'(c));
      end
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_clear[c]) begin
          wp[c]      <= '0;
          rp[c]      <= '0;
          fill_q[c]  <= '0;
          total_q[c] <= '0;
        end else if (acc_wr && (slot_ch == CH_W'(c))) begin
          wp[c]      <= wp[c] + 1'b1;
          fill_q[c]  <= fill_q[c] + 1'b1;
          total_q[c] <= total_q[c] + 32'd1;
        end else if (acc_rd && (slot_ch == CH_W'(c))) begin
          rp[c]     <= rp[c] + 1'b1;
          fill_q[c] <= fill_q[c] - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: FWFT source FIFOs, a synchronous SRAM and sink
// loggers are modelled here; expected values are hand-computed constants.
module tb_mem_arbiter_rr;

  localparam int NUM_CH = 4;
  localparam int DW     = 16;
  localparam int DL2    = 10;
  localparam int AW     = 23;
  localparam int FW     = DL2 + 1;
  localparam int LOGN   = 4096;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NUM_CH-1:0]    ch_enable = '0;
  logic [NUM_CH-1:0]    ch_clear = '0;
  logic [NUM_CH*DW-1:0] wsrc_data;
  logic [NUM_CH-1:0]    wsrc_valid;
  logic [NUM_CH-1:0]    wsrc_rd;
  logic [DW-1:0]        rdst_data;
  logic [NUM_CH-1:0]    rdst_wr;
  logic [NUM_CH-1:0]    rdst_afull = '1;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic [DW-1:0]        mem_rdata = '0;
  logic                 mem_en;
  logic                 mem_we;
  logic [NUM_CH*FW-1:0] fill;
  logic [NUM_CH-1:0]    full;
  logic [NUM_CH*32-1:0] wr_total;

  mem_arbiter_rr #(.NUM_CH(NUM_CH), .DATA_W(DW), .DEPTH_LOG2(DL2), .ADDR_W(AW),
                   .MAX_BURST(16)) dut (
    .clk(clk), .reset(reset), .ch_enable(ch_enable), .ch_clear(ch_clear),
    .wsrc_data(wsrc_data), .wsrc_valid(wsrc_valid), .wsrc_rd(wsrc_rd),
    .rdst_data(rdst_data), .rdst_wr(rdst_wr), .rdst_afull(rdst_afull),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .fill(fill), .full(full), .wr_total(wr_total));

  always #5 clk = ~clk;

  // Source FIFOs
  logic [DW-1:0] src_buf  [NUM_CH][2048];
  int            src_head [NUM_CH] = '{default: 0};
  int            src_tail [NUM_CH] = '{default: 0};
  logic [NUM_CH-1:0] pop_lat = '0;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      wsrc_valid[c]       = (src_head[c] != src_tail[c]);
      wsrc_data[c*DW +: DW] = src_buf[c][src_head[c] % 2048];
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) src_head[c] <= src_head[c] + int'(pop_lat[c]);
  end

  // SRAM model: request latched mid-cycle, acted on at the edge
  logic [DW-1:0] sram [LOGN];
  logic          s_en = 1'b0, s_we = 1'b0;
  logic [11:0]   s_addr = '0;
  logic [DW-1:0] s_wdata = '0;

  always @(posedge clk) begin
    if (s_en && s_we)  sram[s_addr] <= s_wdata;
    if (s_en && !s_we) mem_rdata <= sram[s_addr];
  end

  // Monitor: access log, pop counts, sink capture and read-return lag
  int            cyc = 0;
  int            acc_n = 0;
  logic [AW-1:0] acc_addr [LOGN];
  logic          acc_we   [LOGN];
  logic [DW-1:0] acc_data [LOGN];
  int            acc_cyc  [LOGN];
  int            pop_cnt  [NUM_CH] = '{default: 0};
  int            snk_cnt  [NUM_CH] = '{default: 0};
  logic [DW-1:0] snk_buf  [NUM_CH][256];
  int            lag_err = 0;
  logic [NUM_CH-1:0] prev_issue = '0;
  logic          prev_rst = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    pop_lat <= wsrc_rd;
    s_en <= mem_en; s_we <= mem_we; s_addr <= mem_addr[11:0]; s_wdata <= mem_wdata;
    if (mem_en && acc_n < LOGN) begin
      acc_addr[acc_n] = mem_addr; acc_we[acc_n] = mem_we;
      acc_data[acc_n] = mem_wdata; acc_cyc[acc_n] = cyc;
      acc_n = acc_n + 1;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      pop_cnt[c] = pop_cnt[c] + int'(wsrc_rd[c]);
      if (rdst_wr[c]) begin
        snk_buf[c][snk_cnt[c] % 256] = rdst_data;
        snk_cnt[c] = snk_cnt[c] + 1;
      end
    end
    if (!reset && !prev_rst && (rdst_wr !== prev_issue)) lag_err = lag_err + 1;
    prev_issue = '0;
    if (!reset && mem_en && !mem_we) prev_issue[mem_addr[11:10]] = 1'b1;
    prev_rst = reset;
  end

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
  endtask

  function automatic int fill_of(input int c);
    return int'(fill[c*FW +: FW]);
  endfunction

  function automatic longint total_of(input int c);
    return longint'(wr_total[c*32 +: 32]);
  endfunction

  function automatic int count_acc(input int from, input int ch, input logic we);
    int n = 0;
    for (int i = from; i < acc_n; i++)
      if (acc_we[i] == we && int'(acc_addr[i][11:10]) == ch) n++;
    return n;
  endfunction

  function automatic int first_acc(input int from, input int ch, input logic we);
    for (int i = from; i < acc_n; i++)
      if (acc_we[i] == we && int'(acc_addr[i][11:10]) == ch) return i;
    return LOGN - 1;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input int c, input int n, input logic [DW-1:0] d0, input logic [DW-1:0] step);
    for (int k = 0; k < n; k++) begin
      src_buf[c][src_tail[c] % 2048] = d0 + DW'(k) * step;
      src_tail[c]++;
    end
  endtask

  task automatic wait_empty(input int c, input int budget, input string name);
    for (int i = 0; i < budget && src_head[c] != src_tail[c]; i++) tick();
    check({name, "_drain"}, longint'(src_tail[c] - src_head[c]), 0);
  endtask

  // Returns at the falling edge of the n-th matching access
  task automatic wait_issue(input int ch, input logic we, input int n, input int budget,
                            input string name);
    int cnt = 0;
    for (int i = 0; i < budget && cnt < n; i++) begin
      @(negedge clk);
      if (mem_en && mem_we == we && int'(mem_addr[11:10]) == ch) cnt++;
    end
    check({name, "_seen"}, longint'(cnt), longint'(n));
  endtask

  typedef struct {
    int            ch;
    int            n;
    logic [DW-1:0] d0;
    logic [DW-1:0] step;
    logic [AW-1:0] a_first;
    logic [AW-1:0] a_last;
    logic [DW-1:0] d_last;
    int            exp_fill;
    int            exp_total;
  } wvec_t;

  wvec_t wv [4];

  initial begin
    int a0, a1, s0, p0, bad, idx, ng;
    int glen [8];
    int gstart [8];
    int gend [8];

    wv[0] = '{0, 5, 16'h1111, 16'h1111, 23'h000, 23'h004, 16'h5555, 5, 5};
    wv[1] = '{2, 7, 16'hA000, 16'h0001, 23'h800, 23'h806, 16'hA006, 7, 7};
    wv[2] = '{3, 3, 16'h3000, 16'h0001, 23'hC00, 23'hC02, 16'h3002, 3, 3};
    wv[3] = '{0, 2, 16'h6666, 16'h1111, 23'h005, 23'h006, 16'h7777, 7, 7};

    // Reset values
    run(3);
    check("rst_mem", longint'({mem_en, mem_we, mem_addr, mem_wdata}), 0);
    check("rst_strobes", longint'({wsrc_rd, rdst_wr, rdst_data}), 0);
    check("rst_fill", longint'({fill, full}), 0);
    check("rst_total", longint'(wr_total[127:64] | wr_total[63:0]), 0);
    reset = 1'b0;
    ch_enable = '1;
    tick();
    check("rst_rdst_after", longint'(rdst_wr), 0);

    // Write vectors; sinks held almost-full so nothing is read back yet
    for (int v = 0; v < 4; v++) begin
      a0 = acc_n; p0 = pop_cnt[wv[v].ch];
      load(wv[v].ch, wv[v].n, wv[v].d0, wv[v].step);
      wait_empty(wv[v].ch, 300, $sformatf("wv%0d", v));
      run(12);
      idx = a0 + wv[v].n - 1; if (idx >= LOGN) idx = LOGN - 1;
      check($sformatf("wv%0d_pops", v), longint'(pop_cnt[wv[v].ch] - p0), longint'(wv[v].n));
      check($sformatf("wv%0d_writes", v), longint'(count_acc(a0, wv[v].ch, 1'b1)), longint'(wv[v].n));
      check($sformatf("wv%0d_accs", v), longint'(acc_n - a0), longint'(wv[v].n));
      check($sformatf("wv%0d_a_first", v), longint'(acc_addr[a0]), longint'(wv[v].a_first));
      check($sformatf("wv%0d_a_last", v), longint'(acc_addr[idx]), longint'(wv[v].a_last));
      check($sformatf("wv%0d_d_last", v), longint'(acc_data[idx]), longint'(wv[v].d_last));
      check($sformatf("wv%0d_fill", v), longint'(fill_of(wv[v].ch)), longint'(wv[v].exp_fill));
      check($sformatf("wv%0d_total", v), total_of(wv[v].ch), longint'(wv[v].exp_total));
    end

    // Drain channel 0: seven reads, data returned in order one cycle later
    a0 = acc_n; s0 = snk_cnt[0];
    rdst_afull[0] = 1'b0;
    run(40);
    rdst_afull[0] = 1'b1;
    check("rd0_reads", longint'(count_acc(a0, 0, 1'b0)), 7);
    check("rd0_a_first", longint'(acc_addr[first_acc(a0, 0, 1'b0)]), 23'h000);
    check("rd0_pulses", longint'(snk_cnt[0] - s0), 7);
    bad = 0;
    for (int k = 0; k < 7; k++) if (snk_buf[0][(s0 + k) % 256] != 16'h1111 * DW'(k + 1)) bad++;
    check("rd0_order", longint'(bad), 0);
    check("rd0_last_data", longint'(snk_buf[0][(s0 + 6) % 256]), 16'h7777);
    check("rd0_fill", longint'(fill_of(0)), 0);
    check("rd_lag", longint'(lag_err), 0);

    // 40 words on channel 1: bursts of 16, 16, 8
    a0 = acc_n;
    load(1, 40, 16'h4000, 16'h0001);
    wait_empty(1, 400, "burst");
    run(12);
    ng = 0; bad = 0;
    for (int i = a0; i < acc_n; i++) begin
      if (acc_addr[i] != AW'(23'h400 + (i - a0)) || !acc_we[i]) bad++;
      if (i == a0 || acc_cyc[i] != acc_cyc[i-1] + 1) begin
        if (ng < 8) begin gstart[ng] = acc_cyc[i]; glen[ng] = 0; end
        ng++;
      end
      if (ng >= 1 && ng <= 8) begin glen[ng-1]++; gend[ng-1] = acc_cyc[i]; end
    end
    check("burst_groups", longint'(ng), 3);
    check("burst_len0", longint'(glen[0]), 16);
    check("burst_len1", longint'(glen[1]), 16);
    check("burst_len2", longint'(glen[2]), 8);
    check("burst_gap", longint'(gstart[1] - gend[0]), 10);
    check("burst_seq", longint'(bad), 0);
    check("burst_fill", longint'(fill_of(1)), 40);

    // Fill channel 1 to capacity; 16 source words must stay unconsumed
    load(1, 1000, 16'h5000, 16'h0001);
    for (int i = 0; i < 5000 && !full[1]; i++) tick();
    a0 = acc_n;
    run(50);
    check("full_flag", longint'(full), 4'b0010);
    check("full_fill", longint'(fill_of(1)), 1024);
    check("full_pops", longint'(pop_cnt[1]), 1024);
    check("full_total", total_of(1), 1024);
    check("full_left", longint'(src_tail[1] - src_head[1]), 16);
    check("full_no_write", longint'(acc_n - a0), 0);

    // Drain one word then expect exactly one write, to the wrapped address
    a0 = acc_n; s0 = snk_cnt[1];
    rdst_afull[1] = 1'b0;
    wait_issue(1, 1'b0, 1, 100, "wrap_rd");
    @(posedge clk); #1;
    rdst_afull[1] = 1'b1;
    run(30);
    check("wrap_reads", longint'(count_acc(a0, 1, 1'b0)), 1);
    check("wrap_rd_addr", longint'(acc_addr[first_acc(a0, 1, 1'b0)]), 23'h400);
    check("wrap_rd_data", longint'(snk_buf[1][s0 % 256]), 16'h4000);
    check("wrap_writes", longint'(count_acc(a0, 1, 1'b1)), 1);
    check("wrap_wr_addr", longint'(acc_addr[first_acc(a0, 1, 1'b1)]), 23'h400);
    check("wrap_wr_data", longint'(acc_data[first_acc(a0, 1, 1'b1)]), 16'h53D8);
    check("wrap_fill", longint'(fill_of(1)), 1024);

    // Sink 2 goes almost-full after three issues
    a0 = acc_n; s0 = snk_cnt[2];
    rdst_afull[2] = 1'b0;
    wait_issue(2, 1'b0, 3, 100, "afull");
    @(posedge clk); #1;
    rdst_afull[2] = 1'b1;
    run(20);
    check("afull_reads", longint'(count_acc(a0, 2, 1'b0)), 3);
    check("afull_pulses", longint'(snk_cnt[2] - s0), 3);
    check("afull_data", longint'(snk_buf[2][(s0 + 2) % 256]), 16'hA002);
    check("afull_fill", longint'(fill_of(2)), 4);
    a1 = acc_n;
    rdst_afull[2] = 1'b0;
    run(40);
    rdst_afull[2] = 1'b1;
    check("afull_rest_reads", longint'(count_acc(a1, 2, 1'b0)), 4);
    check("afull_rest_addr", longint'(acc_addr[first_acc(a1, 2, 1'b0)]), 23'h803);
    bad = 0;
    for (int k = 0; k < 7; k++) if (snk_buf[2][(s0 + k) % 256] != 16'hA000 + DW'(k)) bad++;
    check("afull_order", longint'(bad), 0);
    check("afull_rest_fill", longint'(fill_of(2)), 0);

    // Clear channel 3 in the middle of a write burst
    p0 = pop_cnt[3];
    load(3, 20, 16'h3100, 16'h0001);
    wait_issue(3, 1'b1, 2, 100, "clr");
    @(posedge clk); #1;
    ch_clear[3] = 1'b1;
    #1;
    check("clr_no_access", longint'({mem_en, wsrc_rd}), 0);
    @(posedge clk); #1;
    ch_clear[3] = 1'b0;
    a0 = acc_n;
    check("clr_fill", longint'(fill_of(3)), 0);
    check("clr_total", total_of(3), 0);
    check("clr_pops", longint'(pop_cnt[3] - p0), 2);
    check("clr_scan", longint'(mem_en), 0);
    wait_empty(3, 300, "clr");
    run(12);
    check("clr_restart_addr", longint'(acc_addr[first_acc(a0, 3, 1'b1)]), 23'hC00);
    check("clr_restart_data", longint'(acc_data[first_acc(a0, 3, 1'b1)]), 16'h3102);
    check("clr_refill", longint'(fill_of(3)), 18);
    check("clr_retotal", total_of(3), 18);

    // Disabled channel is never serviced
    ch_enable[3] = 1'b0;
    rdst_afull[3] = 1'b0;
    a0 = acc_n;
    run(30);
    check("dis_no_access", longint'(acc_n - a0), 0);
    check("dis_fill", longint'(fill_of(3)), 18);

    // Reset while a read is in flight discards its return strobe
    ch_enable[3] = 1'b1;
    wait_issue(3, 1'b0, 1, 100, "rst_rd");
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst2_rdst", longint'(rdst_wr), 0);
    check("rst2_fill", longint'(fill), 0);
    check("rst2_mem_en", longint'(mem_en), 0);
    run(2);
    reset = 1'b0;
    tick();
    check("rst2_rdst_after", longint'(rdst_wr), 0);
    check("rd_lag_final", longint'(lag_err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
